// File: rtl/count_up_pkg.sv
// Shared types and constants for the BCD count-up timer.
// Used by count_up_timer and bcd_digit_counter.
package count_up_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

  function automatic logic [31:0] bcd_all_nines(input int digits);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < digits) v[4*i +: 4] = BCD_DIGIT_MAX;
    end
    return v;
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit of the elapsed count; digits chain via carry_out.
// Clears on clr, steps 0..9 on inc, wrapping 9 -> 0.
module bcd_digit_counter
  import count_up_pkg::*;
(
  input  logic       clk_250,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] digit,
  output logic       carry_out
);

  logic at_max;

  assign at_max    = (digit == BCD_DIGIT_MAX);
  assign carry_out = inc & at_max;

  always_ff @(posedge clk_250 or negedge rst) begin
    if (!rst) begin
      digit <= 4'd0;
    end else if (clr) begin
      digit <= 4'd0;
    end else if (inc) begin
      digit <= at_max ? 4'd0 : digit + 4'd1;
    end
  end

endmodule

// File: rtl/count_up_timer.sv
// Up-counting BCD elapsed-time timer with valid/ack result handshake.
// Define COUNT_UP_STOP_SYNC_EN to pass stop through a 2-flop synchronizer.
module count_up_timer
  import count_up_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic              clk_250,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              ack,
  output logic              busy,
  output logic              result_valid,
  output logic [4*DIGITS-1:0] elapsed,
  output logic              overflow
);

  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] ALL9 = W'(bcd_all_nines(DIGITS));

  state_t          state_q;
  state_t          state_d;
  logic            stop_eff;
  logic            clr;
  logic            inc;
  logic            sat;
  logic            set_ovf;
  logic [DIGITS:0] carry;
  logic            carry_unused;

`ifdef COUNT_UP_STOP_SYNC_EN
  logic stop_s1;
  logic stop_s2;

  always_ff @(posedge clk_250 or negedge rst) begin
    if (!rst) begin
      stop_s1 <= 1'b0;
      stop_s2 <= 1'b0;
    end else begin
      stop_s1 <= stop;
      stop_s2 <= stop_s1;
    end
  end

  assign stop_eff = stop_s2;
`else
  assign stop_eff = stop;
`endif

  assign sat = (elapsed == ALL9);

  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    inc     = 1'b0;
    set_ovf = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          clr     = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (stop_eff) begin
          state_d = DONE;
        end else if (sat) begin
          set_ovf = 1'b1;
          state_d = DONE;
        end else begin
          inc = 1'b1;
        end
      end
      DONE: begin
        if (ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_250 or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy         <= (state_d == RUN);
      result_valid <= (state_d == DONE);
      if (clr) begin
        overflow <= 1'b0;
      end else if (set_ovf) begin
        overflow <= 1'b1;
      end
    end
  end

  // Ripple carry: digit g steps only when all lower digits wrap.
  assign carry[0] = inc;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_counter u_digit (
      .clk_250   (clk_250),
      .rst       (rst),
      .clr       (clr),
      .inc       (carry[g]),
      .digit     (elapsed[4*g +: 4]),
      .carry_out (carry[g+1])
    );
  end

  // Top carry never fires: counting halts at all-9s.
  assign carry_unused = carry[DIGITS];

endmodule

// File: tb/tb_count_up_timer.sv
// Scoreboard bench for count_up_timer (DIGITS=4).
// Expected results are queued at stimulus and popped on result_valid rise.
module tb_count_up_timer;

  typedef struct packed {
    logic [15:0] el;
    logic        ov;
  } exp_t;

`ifdef COUNT_UP_STOP_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic        clk_250;
  logic        rst;
  logic        start;
  logic        stop;
  logic        ack;
  logic        busy;
  logic        result_valid;
  logic [15:0] elapsed;
  logic        overflow;

  int   nchk;
  int   nerr;
  int   cyc;
  int   t0;
  logic rv_q;
  exp_t sb[$];

  count_up_timer #(.DIGITS(4)) dut (
    .clk_250      (clk_250),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .ack          (ack),
    .busy         (busy),
    .result_valid (result_valid),
    .elapsed      (elapsed),
    .overflow     (overflow)
  );

  initial clk_250 = 1'b0;
  always #5 clk_250 = ~clk_250;

  always @(posedge clk_250) cyc = cyc + 1;

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int          t;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic bcd_ok(input logic [15:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  // Scoreboard consumer and continuous BCD legality monitor.
  always @(negedge clk_250) begin
    exp_t e;
    if (rst && busy) check("bcd_nibble", 32'(bcd_ok(elapsed)), 32'd1);
    if (rst && result_valid && !rv_q) begin
      if (sb.size() == 0) begin
        check("sb_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("sb_elapsed", 32'(elapsed), 32'(e.el));
        check("sb_overflow", 32'(overflow), 32'(e.ov));
      end
    end
    rv_q = result_valid;
  end

  task automatic step();
    @(posedge clk_250);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    t0 = cyc;
  endtask

  // Advance until the next edge to occur is relative edge n.
  task automatic goto(input int n);
    while (cyc < t0 + n - 1) step();
  endtask

  task automatic wait_rv(input int budget);
    int i;
    i = 0;
    while (!result_valid && i < budget) begin
      step();
      i++;
    end
    check("rv_timeout", 32'(result_valid), 32'd1);
  endtask

  initial begin
    exp_t e;
    nchk  = 0;
    nerr  = 0;
    cyc   = 0;
    t0    = 0;
    rv_q  = 1'b0;
    rst   = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    ack   = 1'b0;

    repeat (3) step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rv", 32'(result_valid), 32'd0);
    check("rst_elapsed", 32'(elapsed), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b1;
    repeat (2) step();

    // Reset mid-run
    do_start();
    @(negedge clk_250);
    check("run_busy0", 32'(busy), 32'd1);
    check("run_el0", 32'(elapsed), 32'd0);
    goto(38);
    check("mid_el37", 32'(elapsed), 32'h0037);
    #2;
    rst = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_elapsed", 32'(elapsed), 32'd0);
    start = 1'b1;
    stop  = 1'b1;
    ack   = 1'b1;
    repeat (2) step();
    check("arst_hold_busy", 32'(busy), 32'd0);
    check("arst_hold_rv", 32'(result_valid), 32'd0);
    check("arst_hold_el", 32'(elapsed), 32'd0);
    start = 1'b0;
    stop  = 1'b0;
    ack   = 1'b0;
    #2;
    rst = 1'b1;
    repeat (4) step();
    check("post_rst_busy", 32'(busy), 32'd0);

    // Basic measurement with a stray start at edge 50
    e.el = to_bcd(126 + LAT - 1);
    e.ov = 1'b0;
    sb.push_back(e);
    do_start();
    goto(50);
    start = 1'b1;
    step();
    start = 1'b0;
    check("glitch_busy", 32'(busy), 32'd1);
    check("glitch_el50", 32'(elapsed), 32'h0050);
    goto(126);
    stop = 1'b1;
    step();
    wait_rv(LAT + 2);
    goto(129);
    stop  = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("done_start_rv", 32'(result_valid), 32'd1);
    check("done_start_busy", 32'(busy), 32'd0);
    check("done_start_el", 32'(elapsed), 32'(to_bcd(126 + LAT - 1)));
    goto(130);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("ack_rv", 32'(result_valid), 32'd0);
    check("ack_busy", 32'(busy), 32'd0);
    check("ack_el_hold", 32'(elapsed), 32'(to_bcd(126 + LAT - 1)));
    repeat (4) step();

    // Short run: stop raised at edge 20
    e.el = to_bcd(20 + LAT - 1);
    e.ov = 1'b0;
    sb.push_back(e);
    do_start();
    goto(20);
    stop = 1'b1;
    step();
    if (LAT == 0) check("short_rv_edge", 32'(result_valid), 32'd1);
    wait_rv(LAT + 2);
    check("short_rv_time", 32'(cyc - t0), 32'(20 + LAT));
    stop = 1'b0;
    ack  = 1'b1;
    step();
    ack = 1'b0;
    check("short_ack_rv", 32'(result_valid), 32'd0);
    repeat (4) step();

    // Saturation with carry boundary checks
    e.el = 16'h9999;
    e.ov = 1'b1;
    sb.push_back(e);
    do_start();
    for (int k = 1; k <= 9999; k++) begin
      step();
      if (k == 9 || k == 10 || k == 99 || k == 100 ||
          k == 999 || k == 1000 || k == 9999) begin
        check("carry_el", 32'(elapsed), 32'(to_bcd(k)));
      end
    end
    check("presat_ovf", 32'(overflow), 32'd0);
    check("presat_rv", 32'(result_valid), 32'd0);
    step();
    check("sat_rv", 32'(result_valid), 32'd1);
    check("sat_ovf", 32'(overflow), 32'd1);
    check("sat_el", 32'(elapsed), 32'h9999);
    repeat (3) step();
    check("sat_hold_el", 32'(elapsed), 32'h9999);
    start = 1'b1;
    step();
    start = 1'b0;
    check("sat_start_rv", 32'(result_valid), 32'd1);
    check("sat_start_busy", 32'(busy), 32'd0);
    start = 1'b1;
    ack   = 1'b1;
    step();
    start = 1'b0;
    ack   = 1'b0;
    check("both_rv", 32'(result_valid), 32'd0);
    check("both_busy", 32'(busy), 32'd0);
    check("both_el", 32'(elapsed), 32'h9999);
    step();
    check("both_idle", 32'(busy), 32'd0);
    repeat (2) step();

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
